ps2_voice_allocator: RTL and testbench

//   Polyphonic successor to the single-register keyboard latch. Parses the raw PS/2 set-2 byte

---
 rtl/synth_pkg.sv | 27 ++
 rtl/ps2_event_parser.sv | 63 ++++++
 rtl/ps2_voice_allocator.sv | 168 ++++++++++++++++
 tb/tb_ps2_voice_allocator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and PS/2 constants for the keyboard synth voice path.
// Used by ps2_event_parser and ps2_voice_allocator.
package synth_pkg;

  localparam int KEY_W = 9;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_t;

  typedef struct packed {
    logic valid;
    logic is_break;
    logic [KEY_W-1:0] key;
  } key_event_t;

  // Controller responses and fillers that never map to a key.
  function automatic logic ps2_ignored(input logic [7:0] c);
    return c inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_event_parser.sv
// PS/2 set-2 byte stream to registered make/break key events.
// flush returns to IDLE and drops any byte arriving with it.
module ps2_event_parser
  import synth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [7:0] code,
  input  logic code_valid,
  input  logic flush,
  output key_event_t ev
);

  ps2_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ev <= '0;
    end else begin
      ev.valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else if (code_valid) begin
        unique case (state)
          IDLE: begin
            if (code == PS2_EXT) begin
              state <= EXT;
            end else if (code == PS2_BREAK) begin
              state <= BRK;
            end else if (!ps2_ignored(code)) begin
              ev <= '{valid: 1'b1, is_break: 1'b0,
                      key: {1'b0, code}};
            end
          end
          EXT: begin
            if (code == PS2_BREAK) begin
              state <= EXT_BRK;
            end else if (code != PS2_EXT) begin
              ev <= '{valid: 1'b1, is_break: 1'b0,
                      key: {1'b1, code}};
              state <= IDLE;
            end
          end
          BRK: begin
            if (code != PS2_BREAK) begin
              ev <= '{valid: 1'b1, is_break: 1'b1,
                      key: {1'b0, code}};
              state <= IDLE;
            end
          end
          EXT_BRK: begin
            ev <= '{valid: 1'b1, is_break: 1'b1,
                    key: {1'b1, code}};
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_voice_allocator.sv
// Polyphonic voice allocator with oldest-voice stealing.
// Optional sustain pedal support via VOICE_SUSTAIN_EN.
module ps2_voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] code_in,
  input  logic code_valid_in,
  input  logic all_off_in,
`ifdef VOICE_SUSTAIN_EN
  input  logic sustain_in,
`endif
  output logic [KEY_W*NUM_VOICES-1:0] voice_key_out,
  output logic [NUM_VOICES-1:0] voice_active_out,
  output logic [NUM_VOICES-1:0] voice_trig_out,
  output logic [NUM_VOICES-1:0] voice_rel_out,
  output logic steal_out
);

  localparam int AGE_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX =
    AGE_W'(NUM_VOICES - 1);

  key_event_t ev;
  logic [KEY_W-1:0] key [NUM_VOICES];
  logic [AGE_W-1:0] age [NUM_VOICES];
  logic [NUM_VOICES-1:0] active;

  logic hit, free_any;
  logic [AGE_W-1:0] hit_idx, free_idx, old_idx, sel_idx;
  logic [AGE_W-1:0] old_age;
  logic ev_make, ev_brk, retrig;
  logic do_alloc, do_steal, do_rel;

  ps2_event_parser u_parser (
    .clk(clk),
    .rst(rst),
    .code(code_in),
    .code_valid(code_valid_in),
    .flush(all_off_in),
    .ev(ev)
  );

`ifdef VOICE_SUSTAIN_EN
  logic [NUM_VOICES-1:0] sus;
  logic sustain_q, fall, do_hold;
  assign fall = sustain_q & ~sustain_in;
`endif

  // Descending scans so the lowest index wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && key[i] == ev.key) begin
        hit = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!active[i]) begin
        free_any = 1'b1;
        free_idx = AGE_W'(i);
      end
    end
  end

  always_comb begin
    old_idx = '0;
    old_age = age[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age[i] > old_age) begin
        old_age = age[i];
        old_idx = AGE_W'(i);
      end
    end
  end

  always_comb begin
    ev_make = ev.valid & ~ev.is_break;
    ev_brk = ev.valid & ev.is_break;
`ifdef VOICE_SUSTAIN_EN
    retrig = ev_make & hit & sus[hit_idx];
    do_rel = ev_brk & hit & ~sustain_in;
    do_hold = ev_brk & hit & sustain_in;
`else
    retrig = 1'b0;
    do_rel = ev_brk & hit;
`endif
    do_alloc = ev_make & (~hit | retrig);
    do_steal = ev_make & ~hit & ~free_any;
    sel_idx = retrig   ? hit_idx :
              free_any ? free_idx : old_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        key[i] <= '0;
        age[i] <= '0;
      end
      active <= '0;
      voice_trig_out <= '0;
      voice_rel_out <= '0;
      steal_out <= 1'b0;
`ifdef VOICE_SUSTAIN_EN
      sus <= '0;
      sustain_q <= 1'b0;
`endif
    end else begin
      voice_trig_out <= '0;
      voice_rel_out <= '0;
      steal_out <= 1'b0;
`ifdef VOICE_SUSTAIN_EN
      sustain_q <= sustain_in;
`endif
      if (all_off_in) begin
        voice_rel_out <= active;
        active <= '0;
`ifdef VOICE_SUSTAIN_EN
        sus <= '0;
`endif
      end else begin
        steal_out <= do_steal;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (do_alloc) begin
            if (AGE_W'(i) == sel_idx) begin
              key[i] <= ev.key;
              active[i] <= 1'b1;
              voice_trig_out[i] <= 1'b1;
              age[i] <= '0;
            end else if (active[i] && age[i] != AGE_MAX) begin
              age[i] <= age[i] + 1'b1;
            end
          end
          if (do_rel && AGE_W'(i) == hit_idx) begin
            active[i] <= 1'b0;
            voice_rel_out[i] <= 1'b1;
          end
`ifdef VOICE_SUSTAIN_EN
          if (do_alloc && AGE_W'(i) == sel_idx) begin
            sus[i] <= 1'b0;
          end else if (fall && sus[i]) begin
            sus[i] <= 1'b0;
            active[i] <= 1'b0;
            voice_rel_out[i] <= 1'b1;
          end else if (do_hold && AGE_W'(i) == hit_idx) begin
            sus[i] <= 1'b1;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    voice_key_out = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_key_out[KEY_W*i +: KEY_W] = key[i];
    end
  end

  assign voice_active_out = active;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed bench for ps2_voice_allocator with hand-computed vectors.
// Sustain checks are included when VOICE_SUSTAIN_EN is defined.
module tb_ps2_voice_allocator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] code_in = '0;
  logic code_valid_in = 1'b0;
  logic all_off_in = 1'b0;
`ifdef VOICE_SUSTAIN_EN
  logic sustain_in = 1'b0;
`endif
  logic [35:0] voice_key_out;
  logic [3:0] voice_active_out;
  logic [3:0] voice_trig_out;
  logic [3:0] voice_rel_out;
  logic steal_out;

  int n_vec = 0;
  int n_err = 0;

  ps2_voice_allocator #(.NUM_VOICES(4)) dut (
    .clk(clk),
    .rst(rst),
    .code_in(code_in),
    .code_valid_in(code_valid_in),
    .all_off_in(all_off_in),
`ifdef VOICE_SUSTAIN_EN
    .sustain_in(sustain_in),
`endif
    .voice_key_out(voice_key_out),
    .voice_active_out(voice_active_out),
    .voice_trig_out(voice_trig_out),
    .voice_rel_out(voice_rel_out),
    .steal_out(steal_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [35:0] got,
                       input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    code_in = b;
    code_valid_in = 1'b1;
    step();
    code_valid_in = 1'b0;
  endtask

  function automatic logic [35:0] k(input int i);
    return 36'(voice_key_out[9*i +: 9]);
  endfunction

  initial begin
    step();
    step();
    check("rst_key", voice_key_out, 36'h0);
    check("rst_act", 36'(voice_active_out), 36'h0);
    check("rst_trig", 36'(voice_trig_out), 36'h0);
    check("rst_rel", 36'(voice_rel_out), 36'h0);
    check("rst_steal", 36'(steal_out), 36'h0);
    rst = 1'b0;
    step();

    // single make
    send(8'h1C);
    check("mk_early", 36'(voice_trig_out), 36'h0);
    step();
    check("mk_key0", k(0), 36'h01C);
    check("mk_act", 36'(voice_active_out), 36'h1);
    check("mk_trig", 36'(voice_trig_out), 36'h1);
    step();
    check("mk_trig_end", 36'(voice_trig_out), 36'h0);

    // typematic repeat
    for (int r = 0; r < 2; r++) begin
      send(8'h1C);
      step();
      check("tm_trig", 36'(voice_trig_out), 36'h0);
      check("tm_act", 36'(voice_active_out), 36'h1);
    end

    // break held key, then unheld key
    send(8'hF0);
    send(8'h1C);
    step();
    check("brk_act", 36'(voice_active_out), 36'h0);
    check("brk_rel", 36'(voice_rel_out), 36'h1);
    check("brk_key0", k(0), 36'h01C);
    step();
    check("brk_rel_end", 36'(voice_rel_out), 36'h0);
    send(8'hF0);
    send(8'h1B);
    step();
    check("brk_unheld", 36'(voice_rel_out), 36'h0);

    // fill all voices, then steal oldest
    send(8'h1C);
    send(8'h1B);
    send(8'h23);
    send(8'h2B);
    step();
    check("fill_act", 36'(voice_active_out), 36'hF);
    check("fill_key3", k(3), 36'h02B);
    send(8'h34);
    step();
    check("st_key0", k(0), 36'h034);
    check("st_trig", 36'(voice_trig_out), 36'h1);
    check("st_steal", 36'(steal_out), 36'h1);
    check("st_rel", 36'(voice_rel_out), 36'h0);
    step();
    check("st_end", 36'(steal_out), 36'h0);
    send(8'hF0);
    send(8'h1C);
    step();
    check("st_brk_rel", 36'(voice_rel_out), 36'h0);
    check("st_brk_act", 36'(voice_active_out), 36'hF);
    // ages now v1=3 v2=2 v3=1 v0=0
    send(8'h3B);
    step();
    check("st2_trig", 36'(voice_trig_out), 36'h2);
    check("st2_key1", k(1), 36'h03B);
    check("st2_steal", 36'(steal_out), 36'h1);

    // panic with a concurrent byte
    all_off_in = 1'b1;
    code_in = 8'h1C;
    code_valid_in = 1'b1;
    step();
    all_off_in = 1'b0;
    code_valid_in = 1'b0;
    check("off_rel", 36'(voice_rel_out), 36'hF);
    check("off_act", 36'(voice_active_out), 36'h0);
    step();
    check("off_rel_end", 36'(voice_rel_out), 36'h0);
    step();
    check("off_drop", 36'(voice_trig_out), 36'h0);
    check("off_drop_act", 36'(voice_active_out), 36'h0);

    // extended keys
    send(8'hE0);
    send(8'h6B);
    step();
    check("ext_key0", k(0), 36'h16B);
    check("ext_trig", 36'(voice_trig_out), 36'h1);
    send(8'hF0);
    send(8'h6B);
    step();
    check("ext_plain_brk", 36'(voice_rel_out), 36'h0);
    check("ext_still", 36'(voice_active_out), 36'h1);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    step();
    check("ext_rel", 36'(voice_rel_out), 36'h1);
    check("ext_act", 36'(voice_active_out), 36'h0);

    // reset mid-sequence
    send(8'hE0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_key", voice_key_out, 36'h0);
    send(8'h1C);
    step();
    check("mid_rst_key0", k(0), 36'h01C);
    check("mid_rst_trig", 36'(voice_trig_out), 36'h1);

`ifdef VOICE_SUSTAIN_EN
    sustain_in = 1'b1;
    send(8'hF0);
    send(8'h1C);
    step();
    check("sus_rel", 36'(voice_rel_out), 36'h0);
    check("sus_act", 36'(voice_active_out), 36'h1);
    sustain_in = 1'b0;
    step();
    check("sus_fall_rel", 36'(voice_rel_out), 36'h1);
    check("sus_fall_act", 36'(voice_active_out), 36'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
